stream_mux_rr: RTL and testbench

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_rr.sv | 94 +++++++++
 tb/tb_stream_mux_rr.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// Packet-aware N:1 stream multiplexer with a registered output slot.
// Arbitration is round-robin (MODE=0) or fixed lowest-index priority (MODE=1).
module stream_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int MODE   = 0,
  localparam int ID_W  = $clog2(NUM_CH)
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [NUM_CH-1:0]        s_valid,
  output logic [NUM_CH-1:0]        s_ready,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic [NUM_CH-1:0]        s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_last,
  output logic [ID_W-1:0]          m_id,
  output logic                     busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] lock_id;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] sel;
  logic            any_valid;
  logic            accept;
  logic            slot_free;

  assign slot_free = !m_valid || m_ready;
  assign busy      = (state == LOCKED);

  // Search order starts at rr_ptr in round-robin mode, at 0 in priority mode.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (MODE == 1) ? k : ((int'(rr_ptr) + k) % NUM_CH);
      if (!any_valid && s_valid[idx]) begin
        any_valid = 1'b1;
        winner    = ID_W'(idx);
      end
    end
  end

  // Reset gates s_ready so nothing upstream sees an accept while held in reset.
  always_comb begin
    s_ready    = '0;
    accept     = 1'b0;
    state_next = state;
    sel        = (state == LOCKED) ? lock_id : winner;
    if (ARESETn && slot_free) begin
      if (state == IDLE) accept = any_valid;
      else               accept = s_valid[sel];
    end
    if (accept) begin
      s_ready[sel] = 1'b1;
      if (state == IDLE && !s_last[sel])  state_next = LOCKED;
      if (state == LOCKED && s_last[sel]) state_next = IDLE;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= IDLE;
      lock_id <= '0;
      rr_ptr  <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_id    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= s_data[int'(sel)*DATA_W +: DATA_W];
        m_last  <= s_last[sel];
        m_id    <= sel;
        if (state == IDLE) lock_id <= sel;
        if (s_last[sel])
          rr_ptr <= (sel == ID_W'(NUM_CH-1)) ? '0 : sel + ID_W'(1);
      end else if (slot_free) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed scoreboard bench for stream_mux_rr: one round-robin and one
// fixed-priority instance, each with its own expected-beat queue.
module tb_stream_mux_rr;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        ACLK;
  logic        ARESETn;
  logic [3:0]  s_valid, s_valid1;
  logic [3:0]  s_ready, s_ready1;
  logic [31:0] s_data;
  logic [3:0]  s_last;
  logic        m_valid, m_valid1;
  logic        m_ready, m_ready1;
  logic [7:0]  m_data, m_data1;
  logic        m_last, m_last1;
  logic [1:0]  m_id, m_id1;
  logic        busy, busy1;

  beat_t q0[$];
  beat_t q1[$];
  int    checks = 0;
  int    errors = 0;

  stream_mux_rr #(.NUM_CH(4), .DATA_W(8), .MODE(0)) u0 (
    .ACLK(ACLK), .ARESETn(ARESETn), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .m_id(m_id), .busy(busy)
  );

  stream_mux_rr #(.NUM_CH(4), .DATA_W(8), .MODE(1)) u1 (
    .ACLK(ACLK), .ARESETn(ARESETn), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid1), .m_ready(m_ready1),
    .m_data(m_data1), .m_last(m_last1), .m_id(m_id1), .busy(busy1)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push0(input logic [1:0] id, input logic [7:0] data, input logic last);
    beat_t b;
    b.id = id; b.data = data; b.last = last;
    q0.push_back(b);
  endtask

  task automatic push1(input logic [1:0] id, input logic [7:0] data, input logic last);
    beat_t b;
    b.id = id; b.data = data; b.last = last;
    q1.push_back(b);
  endtask

  // Monitors: pop one expected beat per output transfer.
  always @(negedge ACLK) begin
    if (ARESETn && m_valid && m_ready) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL rr_unexpected_beat actual id=%0d data=%0h expected none", m_id, m_data);
      end else begin
        beat_t e;
        e = q0.pop_front();
        check_output("rr_id", 32'(m_id), 32'(e.id));
        check_output("rr_data", 32'(m_data), 32'(e.data));
        check_output("rr_last", 32'(m_last), 32'(e.last));
      end
    end
  end

  always @(negedge ACLK) begin
    if (ARESETn && m_valid1 && m_ready1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL fp_unexpected_beat actual id=%0d data=%0h expected none", m_id1, m_data1);
      end else begin
        beat_t e;
        e = q1.pop_front();
        check_output("fp_id", 32'(m_id1), 32'(e.id));
        check_output("fp_data", 32'(m_data1), 32'(e.data));
        check_output("fp_last", 32'(m_last1), 32'(e.last));
      end
    end
  end

  task automatic apply_stimulus();
    // Reset state, with s_ready gated while reset is held
    ARESETn = 1'b0; s_valid = '0; s_valid1 = '0; s_last = 4'hF;
    s_data = {8'd13, 8'd12, 8'd11, 8'd10}; m_ready = 1'b1; m_ready1 = 1'b1;
    repeat (2) tick();
    s_valid = 4'hF; s_valid1 = 4'hF;
    #1;
    check_output("rst_m_valid", 32'(m_valid), 0);
    check_output("rst_m_data", 32'(m_data), 0);
    check_output("rst_m_id", 32'(m_id), 0);
    check_output("rst_m_last", 32'(m_last), 0);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_s_ready", 32'(s_ready), 0);
    check_output("rst_s_ready1", 32'(s_ready1), 0);
    s_valid = '0; s_valid1 = '0;
    ARESETn = 1'b1;

    // Round-robin rotation over all channels with single-beat packets
    s_valid = 4'hF;
    push0(0, 8'd10, 1); push0(1, 8'd11, 1); push0(2, 8'd12, 1);
    push0(3, 8'd13, 1); push0(0, 8'd10, 1);
    repeat (5) tick();
    s_valid = '0;
    tick();
    check_output("rot_drained", 32'(q0.size()), 0);
    check_output("rot_idle_m_valid", 32'(m_valid), 0);

    // Move pointer to ch2, then a 3-beat locked packet on ch2 with a stall
    s_valid = 4'b0010; push0(1, 8'd11, 1);
    tick();
    s_valid = 4'b0111; s_last = 4'b1011; s_data[23:16] = 8'hA0; push0(2, 8'hA0, 0);
    #1 check_output("pkt_grant_ch2", 32'(s_ready), 32'h4);
    tick();
    check_output("pkt_busy_a0", 32'(busy), 1);
    s_valid = 4'b0011;
    #1 check_output("pkt_stall_s_ready", 32'(s_ready), 0);
    tick();
    check_output("pkt_stall_busy", 32'(busy), 1);
    check_output("pkt_stall_m_valid", 32'(m_valid), 0);
    s_valid = 4'b0111; s_data[23:16] = 8'hA1; push0(2, 8'hA1, 0);
    #1 check_output("pkt_locked_s_ready", 32'(s_ready), 32'h4);
    tick();
    s_data[23:16] = 8'hA2; s_last = 4'hF; push0(2, 8'hA2, 1);
    tick();
    check_output("pkt_released_busy", 32'(busy), 0);
    s_valid = 4'b0011; s_data[23:16] = 8'd12; push0(0, 8'd10, 1);
    #1 check_output("pkt_wrap_to_ch0", 32'(s_ready), 32'h1);
    tick();
    s_valid = '0;
    tick();
    check_output("pkt_drained", 32'(q0.size()), 0);

    // Backpressure: output held for 3 cycles, no input accepted
    s_valid = 4'b0010; push0(1, 8'd11, 1);
    tick();
    m_ready = 1'b0; s_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output("bp_s_ready", 32'(s_ready), 0);
      check_output("bp_m_data", 32'(m_data), 32'd11);
      check_output("bp_m_id", 32'(m_id), 1);
      tick();
    end
    check_output("bp_m_valid_held", 32'(m_valid), 1);
    m_ready = 1'b1; push0(2, 8'd12, 1);
    #1 check_output("bp_release_grant", 32'(s_ready), 32'h4);
    tick();
    s_valid = '0;
    tick();
    check_output("bp_drained", 32'(q0.size()), 0);

    // Reset asserted mid-packet on ch1, then arbitration restarts at ch0
    s_valid = 4'b0010; s_last = 4'b1101; push0(1, 8'd11, 0);
    tick();
    @(negedge ACLK);
    #1;
    ARESETn = 1'b0; s_valid = 4'b0011; s_last = 4'hF;
    #1;
    check_output("mid_rst_m_valid", 32'(m_valid), 0);
    check_output("mid_rst_m_data", 32'(m_data), 0);
    check_output("mid_rst_m_id", 32'(m_id), 0);
    check_output("mid_rst_busy", 32'(busy), 0);
    check_output("mid_rst_s_ready", 32'(s_ready), 0);
    tick();
    ARESETn = 1'b1; push0(0, 8'd10, 1);
    #1 check_output("mid_rst_restart_ch0", 32'(s_ready), 32'h1);
    tick();
    s_valid = '0;
    tick();
    check_output("mid_rst_drained", 32'(q0.size()), 0);

    // Fixed priority: ch0 always wins, otherwise lowest valid index
    s_valid1 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      push1(0, 8'd10, 1);
      #1 check_output("fp_s_ready_ch0", 32'(s_ready1), 32'h1);
      tick();
    end
    s_valid1 = 4'b1100; push1(2, 8'd12, 1);
    #1 check_output("fp_s_ready_ch2", 32'(s_ready1), 32'h4);
    tick();
    s_valid1 = '0;
    tick();
    check_output("fp_drained", 32'(q1.size()), 0);
  endtask

  initial begin
    apply_stimulus();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
